// File: rtl/pipe_pkg.sv
// Shared front-end constants: reset vector, bubble instruction and
// the decoded control bundle layout used by decode and the D->E register.
package pipe_pkg;

  localparam logic [31:0] RESET_PC  = 32'h0000_0000;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  localparam int CTRL_W = 16;
  localparam int CNT_W  = 16;

  // Bit positions inside the control bundle
  localparam int CTRL_REGW   = 0;
  localparam int CTRL_MEMW   = 1;
  localparam int CTRL_JUMP   = 2;
  localparam int CTRL_BRANCH = 3;
  localparam int CTRL_ALUSRC = 4;
  localparam int CTRL_RES_LO = 5;
  localparam int CTRL_RES_HI = 6;
  localparam int CTRL_ALU_LO = 7;
  localparam int CTRL_ALU_HI = 9;

endpackage

// File: rtl/pipe_front_regs_sat_counter.sv
// Saturating event counter with synchronous clear.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] cnt
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc && (cnt != '1)) begin
      cnt <= cnt + W'(1);
    end
  end

endmodule

// File: rtl/pipe_front_regs.sv
// Fetch PC, IF/ID and ID/EX registers driven by hazard stall/flush,
// plus stall/flush performance counters.
module pipe_front_regs #(
  parameter logic [31:0] RESET_PC  = pipe_pkg::RESET_PC,
  parameter logic [31:0] NOP_INSTR = pipe_pkg::NOP_INSTR,
  parameter int          CTRL_W    = pipe_pkg::CTRL_W,
  parameter int          CNT_W     = pipe_pkg::CNT_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              StallF,
  input  logic              StallD,
  input  logic              FlushD,
  input  logic              FlushE,
  input  logic              PCSrcE,
  input  logic [31:0]       PCTargetE,
  input  logic [31:0]       InstrF,
  input  logic [CTRL_W-1:0] CtrlD,
  input  logic [4:0]        RdD,
  input  logic              cnt_clr,
  output logic [31:0]       PCF,
  output logic [31:0]       PCPlus4F,
  output logic [31:0]       InstrD,
  output logic [31:0]       PCD,
  output logic [31:0]       PCPlus4D,
  output logic              ValidD,
  output logic [CTRL_W-1:0] CtrlE,
  output logic [4:0]        RdE,
  output logic              ValidE,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  flush_cnt,
  output logic              hz_conflict
);

  assign PCPlus4F = PCF + 32'd4;

  // Redirect beats stall: a resolved branch must not be lost
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      PCF <= RESET_PC;
    end else if (PCSrcE) begin
      PCF <= PCTargetE;
    end else if (!StallF) begin
      PCF <= PCPlus4F;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hz_conflict <= 1'b0;
    end else if (PCSrcE && StallF) begin
      hz_conflict <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      InstrD   <= NOP_INSTR;
      PCD      <= '0;
      PCPlus4D <= '0;
      ValidD   <= 1'b0;
    end else if (FlushD) begin
      InstrD   <= NOP_INSTR;
      ValidD   <= 1'b0;
    end else if (!StallD) begin
      InstrD   <= InstrF;
      PCD      <= PCF;
      PCPlus4D <= PCPlus4F;
      ValidD   <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      CtrlE  <= '0;
      RdE    <= '0;
      ValidE <= 1'b0;
    end else if (FlushE) begin
      CtrlE  <= '0;
      RdE    <= '0;
      ValidE <= 1'b0;
    end else begin
      CtrlE  <= CtrlD;
      RdE    <= RdD;
      ValidE <= ValidD;
    end
  end

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (StallF),
    .clr   (cnt_clr),
    .cnt   (stall_cnt)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (FlushD | FlushE),
    .clr   (cnt_clr),
    .cnt   (flush_cnt)
  );

endmodule

// File: tb/tb_pipe_front_regs.sv
// Scoreboard bench: stimulus pushes model expectations, monitor
// pops and compares after each rising edge.
module tb_pipe_front_regs;

  localparam int CW = 16;
  localparam int NW = 4;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          StallF = 0, StallD = 0, FlushD = 0, FlushE = 0;
  logic          PCSrcE = 0, cnt_clr = 0;
  logic [31:0]   PCTargetE = '0, InstrF = '0;
  logic [CW-1:0] CtrlD = '0;
  logic [4:0]    RdD = '0;
  logic [31:0]   PCF, PCPlus4F, InstrD, PCD, PCPlus4D;
  logic          ValidD, ValidE, hz_conflict;
  logic [CW-1:0] CtrlE;
  logic [4:0]    RdE;
  logic [NW-1:0] stall_cnt, flush_cnt;

  pipe_front_regs #(
    .RESET_PC  (32'h0),
    .NOP_INSTR (NOP),
    .CTRL_W    (CW),
    .CNT_W     (NW)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .StallF(StallF), .StallD(StallD),
    .FlushD(FlushD), .FlushE(FlushE),
    .PCSrcE(PCSrcE), .PCTargetE(PCTargetE),
    .InstrF(InstrF), .CtrlD(CtrlD), .RdD(RdD),
    .cnt_clr(cnt_clr),
    .PCF(PCF), .PCPlus4F(PCPlus4F),
    .InstrD(InstrD), .PCD(PCD), .PCPlus4D(PCPlus4D),
    .ValidD(ValidD), .CtrlE(CtrlE), .RdE(RdE),
    .ValidE(ValidE), .stall_cnt(stall_cnt),
    .flush_cnt(flush_cnt), .hz_conflict(hz_conflict)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0]   pc, instr, pcd, pc4d;
    logic          vd, ve, hz;
    logic [CW-1:0] ctrl;
    logic [4:0]    rd;
    int            sc, fc;
  } exp_t;

  exp_t q[$];
  exp_t m;
  int total = 0;
  int bad = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s got=%h want=%h t=%0t", nm, act, want, $time);
    end
  endtask

  task automatic model_reset();
    m.pc = 32'h0; m.instr = NOP; m.pcd = 0; m.pc4d = 0;
    m.vd = 0; m.ve = 0; m.hz = 0; m.ctrl = 0; m.rd = 0;
    m.sc = 0; m.fc = 0;
  endtask

  // Expected pipeline state after one clock edge with the given controls
  task automatic step(input bit sf, input bit sd, input bit fd,
                      input bit fe, input bit ps,
                      input logic [31:0] tgt, input logic [31:0] ins,
                      input logic [CW-1:0] ctl, input logic [4:0] rd,
                      input bit clr);
    exp_t n;
    int lim;
    @(negedge clk);
    StallF = sf; StallD = sd; FlushD = fd; FlushE = fe;
    PCSrcE = ps; PCTargetE = tgt; InstrF = ins;
    CtrlD = ctl; RdD = rd; cnt_clr = clr;
    lim = (1 << NW) - 1;
    n = m;
    n.pc = ps ? tgt : (sf ? m.pc : m.pc + 32'd4);
    if (ps && sf) n.hz = 1;
    if (fd) begin
      n.instr = NOP; n.vd = 0;
    end else if (!sd) begin
      n.instr = ins; n.pcd = m.pc; n.pc4d = m.pc + 32'd4; n.vd = 1;
    end
    if (fe) begin
      n.ctrl = 0; n.rd = 0; n.ve = 0;
    end else begin
      n.ctrl = ctl; n.rd = rd; n.ve = m.vd;
    end
    if (clr) begin
      n.sc = 0; n.fc = 0;
    end else begin
      if (sf) n.sc = (m.sc < lim) ? m.sc + 1 : lim;
      if (fd || fe) n.fc = (m.fc < lim) ? m.fc + 1 : lim;
    end
    q.push_back(n);
    m = n;
  endtask

  task automatic idle(input int k);
    for (int i = 0; i < k; i++)
      step(0, 0, 0, 0, 0, 0, $urandom, 16'($urandom), 5'($urandom), 0);
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_pcf"}, PCF, 32'h0);
    chk({tag, "_instrd"}, InstrD, NOP);
    chk({tag, "_pcd"}, PCD, 0);
    chk({tag, "_pc4d"}, PCPlus4D, 0);
    chk({tag, "_vd"}, {31'b0, ValidD}, 0);
    chk({tag, "_ctrle"}, {16'b0, CtrlE}, 0);
    chk({tag, "_rde"}, {27'b0, RdE}, 0);
    chk({tag, "_ve"}, {31'b0, ValidE}, 0);
    chk({tag, "_scnt"}, {28'b0, stall_cnt}, 0);
    chk({tag, "_fcnt"}, {28'b0, flush_cnt}, 0);
    chk({tag, "_hz"}, {31'b0, hz_conflict}, 0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 0;
    {StallF, StallD, FlushD, FlushE, PCSrcE, cnt_clr} = '0;
    #1 chk_reset("rst");
    @(posedge clk);
    #3 rst_n = 1;
    model_reset();
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("pcf", PCF, e.pc);
        chk("pcplus4f", PCPlus4F, e.pc + 32'd4);
        chk("instrd", InstrD, e.instr);
        chk("pcd", PCD, e.pcd);
        chk("pcplus4d", PCPlus4D, e.pc4d);
        chk("validd", {31'b0, ValidD}, {31'b0, e.vd});
        chk("ctrle", {16'b0, CtrlE}, {16'b0, e.ctrl});
        chk("rde", {27'b0, RdE}, {27'b0, e.rd});
        chk("valide", {31'b0, ValidE}, {31'b0, e.ve});
        chk("stall_cnt", {28'b0, stall_cnt}, e.sc);
        chk("flush_cnt", {28'b0, flush_cnt}, e.fc);
        chk("hz", {31'b0, hz_conflict}, {31'b0, e.hz});
      end
    end
  end

  initial begin : stim
    bit sf, sd, fd, fe, ps;
    int w;
    model_reset();
    do_reset();
    // Plain fetch, then a stall at PCF=0x8
    idle(2);
    step(1, 1, 0, 1, 0, 0, $urandom, 16'h1234, 5'd7, 0);
    idle(2);
    // Taken branch with both flushes
    step(0, 0, 1, 1, 1, 32'h100, $urandom, 16'hbeef, 5'd3, 0);
    idle(2);
    // Redirect while fetch is stalled
    step(1, 1, 0, 1, 1, 32'h200, $urandom, 16'h0, 5'd0, 0);
    idle(3);
    // Random hazard mix
    for (int i = 0; i < 300; i++) begin
      sf = ($urandom_range(0, 3) == 0);
      sd = sf;
      fd = ($urandom_range(0, 5) == 0);
      ps = fd;
      fe = sd | fd | ($urandom_range(0, 7) == 0);
      step(sf, sd, fd, fe, ps, $urandom & 32'hffff_fffc, $urandom,
           16'($urandom), 5'($urandom), $urandom_range(0, 40) == 0);
    end
    // Saturation, then clear under an active stall
    do_reset();
    for (int i = 0; i < 20; i++)
      step(1, 1, 0, 1, 0, 0, $urandom, 16'($urandom), 5'($urandom), 0);
    step(1, 1, 0, 1, 0, 0, $urandom, 16'h0, 5'd0, 1);
    idle(2);
    // Asynchronous reset between edges during a stall
    step(1, 1, 0, 1, 0, 0, $urandom, 16'h0, 5'd0, 0);
    step(1, 1, 0, 1, 1, 32'h40, $urandom, 16'h0, 5'd0, 0);
    @(posedge clk);
    #3 rst_n = 0;
    #1 chk_reset("async");
    @(negedge clk);
    chk_reset("async_hold");
    @(posedge clk);
    #3 rst_n = 1;
    model_reset();
    idle(3);
    w = 0;
    while (q.size() > 0 && w < 50) begin
      @(posedge clk);
      w++;
    end
    #2;
    total++;
    if (q.size() != 0) begin
      bad++;
      $display("FAIL drain got=%0d want=0", q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
